// File: rtl/mill_modif_pkg.sv
// Shared definitions for the Modified Miller encoder: timing defaults, FSM encoding
// and the X/Y/Z sequence codes used by both mill_modif_mod and mill_modif_demod.
package mill_modif_pkg;

    localparam int unsigned ETU_LEN_DEF   = 32;
    localparam int unsigned PAUSE_LEN_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSof,
        StData,
        StPar,
        StEof0,
        StEofY
    } state_t;

    typedef enum logic [1:0] {
        SeqY = 2'd0,
        SeqX = 2'd1,
        SeqZ = 2'd2
    } seq_t;

    // A 1 is always X; a 0 is Y after a 1 and Z after a 0.
    function automatic seq_t miller_code(input logic b, input logic prev);
        if (b) begin
            return SeqX;
        end
        return prev ? SeqY : SeqZ;
    endfunction

endpackage

// File: rtl/mill_modif_etu_timer.sv
// Bit-period counter with end-of-ETU strobe and pause-window decode. The decode is done
// on the next counter value so the caller can register the carrier-enable output.
module mill_modif_etu_timer
    import mill_modif_pkg::*;
#(
    parameter int unsigned ETU_LEN   = ETU_LEN_DEF,
    parameter int unsigned PAUSE_LEN = PAUSE_LEN_DEF
) (
    input  logic clk,
    input  logic in_PoR,
    input  logic active,
    input  seq_t seq,
    output logic etu_end,
    output logic pause_next
);

    localparam int unsigned CntW = $clog2(ETU_LEN);
    localparam logic [CntW-1:0] LastCnt = CntW'(ETU_LEN - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(ETU_LEN / 2);
    localparam logic [CntW-1:0] PauseW  = CntW'(PAUSE_LEN);

    logic [CntW-1:0] cnt_q, cnt_d, x_off;

    always_comb begin
        etu_end = active && (cnt_q == LastCnt);
        if (!active || etu_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        x_off      = cnt_d - HalfCnt;
        pause_next = 1'b0;
        unique case (seq)
            SeqZ:    pause_next = (cnt_d < PauseW);
            SeqX:    pause_next = (cnt_d >= HalfCnt) && (x_off < PauseW);
            default: pause_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!in_PoR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mill_modif_mod.sv
// Modified Miller encoder, ISO 14443-A reader-to-card at 106 kbit/s.
// Optional odd parity per byte when MILL_MODIF_PARITY_EN is defined.
module mill_modif_mod
    import mill_modif_pkg::*;
#(
    parameter int unsigned ETU_LEN   = ETU_LEN_DEF,
    parameter int unsigned PAUSE_LEN = PAUSE_LEN_DEF
) (
    input  logic       clk,
    input  logic       in_PoR,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic       out_ready,
    output logic       out_data,
    output logic       out_busy,
    output logic       out_err
);

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       hold_last_q, hold_last_d;
    logic [7:0] shift_q, shift_d;
    logic       cur_last_q, cur_last_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       prev_q, prev_d;
`ifdef MILL_MODIF_PARITY_EN
    logic       par_q, par_d;
`endif
    logic       out_data_q, busy_q, err_q, err_d;
    logic       accept, load, byte_done;
    logic       etu_end, pause_next;
    seq_t       seq_next;

    mill_modif_etu_timer #(
        .ETU_LEN  (ETU_LEN),
        .PAUSE_LEN(PAUSE_LEN)
    ) u_etu_timer (
        .clk       (clk),
        .in_PoR    (in_PoR),
        .active    (state_q != StIdle),
        .seq       (seq_next),
        .etu_end   (etu_end),
        .pause_next(pause_next)
    );

    always_comb begin
        accept       = in_valid && !hold_valid_q;
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
        shift_d      = shift_q;
        cur_last_d   = cur_last_q;
        bit_idx_d    = bit_idx_q;
        prev_d       = prev_q;
`ifdef MILL_MODIF_PARITY_EN
        par_d        = par_q;
`endif
        err_d        = 1'b0;
        load         = 1'b0;
        byte_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hold_valid_q) begin
                    state_d = StSof;
                    load    = 1'b1;
                end
            end
            StSof: begin
                if (etu_end) begin
                    state_d = StData;
                    prev_d  = 1'b0;
                end
            end
            StData: begin
                if (etu_end) begin
                    prev_d    = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef MILL_MODIF_PARITY_EN
                        state_d = StPar;
`else
                        byte_done = 1'b1;
`endif
                    end
                end
            end
`ifdef MILL_MODIF_PARITY_EN
            StPar: begin
                if (etu_end) begin
                    prev_d    = par_q;
                    byte_done = 1'b1;
                end
            end
`endif
            StEof0: begin
                if (etu_end) begin
                    state_d = StEofY;
                    prev_d  = 1'b0;
                end
            end
            StEofY: begin
                if (etu_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Byte boundary: continue with the held byte, close the frame, or flag underrun.
        if (byte_done) begin
            if (cur_last_q) begin
                state_d = StEof0;
            end else if (hold_valid_q) begin
                state_d = StData;
                load    = 1'b1;
            end else begin
                state_d = StEof0;
                err_d   = 1'b1;
            end
        end

        if (load) begin
            shift_d      = hold_q;
            cur_last_d   = hold_last_q;
            hold_valid_d = 1'b0;
            bit_idx_d    = 3'd0;
`ifdef MILL_MODIF_PARITY_EN
            par_d        = ~(^hold_q);
`endif
        end

        if (accept) begin
            hold_d       = in_byte;
            hold_last_d  = in_last;
            hold_valid_d = 1'b1;
        end
    end

    // Sequence shape of the cycle that follows the next edge.
    always_comb begin
        seq_next = SeqY;
        unique case (state_d)
            StSof:   seq_next = SeqZ;
            StData:  seq_next = miller_code(shift_d[0], prev_d);
`ifdef MILL_MODIF_PARITY_EN
            StPar:   seq_next = miller_code(par_d, prev_d);
`endif
            StEof0:  seq_next = miller_code(1'b0, prev_d);
            default: seq_next = SeqY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!in_PoR) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            shift_q      <= '0;
            cur_last_q   <= 1'b0;
            bit_idx_q    <= '0;
            prev_q       <= 1'b0;
`ifdef MILL_MODIF_PARITY_EN
            par_q        <= 1'b0;
`endif
            out_data_q   <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            bit_idx_q    <= bit_idx_d;
            prev_q       <= prev_d;
`ifdef MILL_MODIF_PARITY_EN
            par_q        <= par_d;
`endif
            out_data_q   <= !pause_next;
            busy_q       <= (state_d != StIdle);
            err_q        <= err_d;
        end
    end

    assign out_ready = !hold_valid_q;
    assign out_data  = out_data_q;
    assign out_busy  = busy_q;
    assign out_err   = err_q;

endmodule
